// File: rtl/mul_share_arbiter_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
// s1_t is sized for the default configuration; the top rejects any other sizing.
package mul_share_pkg;

  localparam int MS_N    = 32;
  localparam int MS_NREQ = 4;
  localparam int MS_IDW  = $clog2(MS_NREQ);

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [MS_N-1:0]   a;
    logic [MS_N-1:0]   b;
    logic [MS_IDW-1:0] id;
    logic              valid;
  } s1_t;

endpackage

// File: rtl/multiplier.sv
// Combinational unsigned N x N -> 2N multiplier.
// Latency 0; no flow control.
module multiplier #(
  parameter int N = 32
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  assign p = {{N{1'b0}}, a} * {{N{1'b0}}, b};

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
// Latency 0; no flow control (caller gates the grant with its own enable).
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one multiplier among NREQ requesters; tagged response bus.
// Latency 2 cycles; rsp_ready low freezes S2, S1 then fills and req_ready drops to 0.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter  int N    = MS_N,
  parameter  int NREQ = MS_NREQ,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N-1:0]      rsp_result,
  output logic [3:0]        rsp_flags,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);

  if (N != MS_N || NREQ != MS_NREQ) begin : g_cfg_check
    $error("mul_share_arbiter: s1_t is sized for N=%0d NREQ=%0d", MS_N, MS_NREQ);
  end

  s1_t              s1;
  logic             s1_en;
  logic             s2_en;
  logic             accept;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   rr_ptr_nxt;
  logic [N-1:0]     sel_a;
  logic [N-1:0]     sel_b;
  logic [2*N-1:0]   prod;
  logic [3:0]       flags_nxt;
  logic             unused_prod_msb;

  assign s2_en = !rsp_valid || rsp_ready;
  assign s1_en = !s1.valid || s2_en;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // grant only ever marks a valid requester, so any ready bit is a handshake
  assign req_ready  = (rst || !s1_en) ? '0 : grant;
  assign accept     = |req_ready;
  assign sel_a      = req_a[int'(grant_idx)*N +: N];
  assign sel_b      = req_b[int'(grant_idx)*N +: N];
  assign rr_ptr_nxt = (int'(grant_idx) == NREQ-1) ? '0 : grant_idx + IDW'(1);

  multiplier #(.N(N)) u_mul (
    .a (s1.a),
    .b (s1.b),
    .p (prod)
  );

  // carry deliberately ignores the top product bit
  always_comb begin
    flags_nxt         = '0;
    flags_nxt[FLAG_Z] = (prod[N-1:0] == '0);
    flags_nxt[FLAG_N] = prod[N-1];
    flags_nxt[FLAG_C] = |prod[2*N-2:N];
    flags_nxt[FLAG_V] = (s1.a[N-1] ~^ s1.b[N-1]) & prod[N-1];
  end

  assign unused_prod_msb = prod[2*N-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= '0;
      rr_ptr     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_id     <= '0;
    end else begin
      if (s1_en) begin
        if (accept) begin
          s1.a     <= sel_a;
          s1.b     <= sel_b;
          s1.id    <= grant_idx;
          s1.valid <= 1'b1;
          rr_ptr   <= rr_ptr_nxt;
        end else begin
          s1.valid <= 1'b0;
        end
      end
      if (s2_en) begin
        rsp_valid <= s1.valid;
        if (s1.valid) begin
          rsp_result <= prod[N-1:0];
          rsp_flags  <= flags_nxt;
          rsp_id     <= s1.id;
        end
      end
    end
  end

  assign busy = s1.valid | rsp_valid;

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one N-bit scalar multiplier datapath among NREQ requesters, e.g. scalar ALU and vector lanes.
- Arbitration is round-robin with a valid/ready handshake on each requester.
- Two-stage pipeline: operand register, then the existing combinational multiplier, then a result register.
- A single tagged response bus returns result, flags and requester id, and supports backpressure.

Parameters:
- N, 32, operand/result width
- NREQ, 4, number of requesters (>=2)
- IDW, $clog2(NREQ), localparam, width of the requester id

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_a  in  NREQ*N  operand A; requester i uses bits [i*N +: N]
- req_b  in  NREQ*N  operand B, same packing as req_a
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts the response
- rsp_result  out  N  low N bits of the product
- rsp_flags  out  4  {z,n,c,v}, bit3 = z
- rsp_id  out  IDW  index of the requester that issued the operation
- busy  out  1  s1_valid | s2_valid

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_id=0, busy=0, s1_valid=0, rr_ptr=0.
- Reset mid-operation: in-flight operations in S1/S2 are discarded and no response is issued for them. req_ready=0 during the cycle rst is high.
- Pipeline enables: s2_en = !s2_valid | rsp_ready; s1_en = !s1_valid | s2_en.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, ascending, wrapping at NREQ-1 -> 0.
  - The first set bit is the grant g. req_ready[g] = s1_en; all other bits are 0.
  - No valid request -> req_ready = 0.
- Accept: req_valid[g] & req_ready[g] in cycle t.
  - At the end of t, S1 captures a, b, id=g and sets s1_valid=1.
  - rr_ptr <= (g+1) mod NREQ.
  - rr_ptr is unchanged when nothing is accepted.
- Stage 2: when s2_en, S2 captures the multiplier outputs for the S1 operands, plus id, with s2_valid <= s1_valid.
  - When s1_en and nothing is accepted, s1_valid <= 0.
- Latency: an operation accepted in cycle t appears with rsp_valid=1 in cycle t+2 if there is no backpressure.
- Throughput: 1 op/cycle.
- Backpressure: while rsp_valid & !rsp_ready, S2 holds every output stable. S1 may fill, then holds; req_ready is then all 0. No data is lost or duplicated.
- Ordering: responses leave in acceptance order.
- Simultaneous events: S2 draining while S1 advances while a new request is accepted is legal and gives full throughput.
- A requester dropping req_valid without a handshake is ignored (no implicit hold). rr_ptr does not advance.
- Arithmetic, computed on the unsigned 2N-bit product P = a*b:
  - result = P[N-1:0]
  - z = (result == 0)
  - n = P[N-1]
  - c = |P[2N-2:N] (bit 2N-1 is deliberately excluded)
  - v = (a[N-1] XNOR b[N-1]) & n
- Flags are registered together with the result.

Decomposition:
- Package mul_share_pkg:
  - flag bit positions FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0
  - typedef of the S1 stage struct (a, b, id, valid)
- Sub-module rr_arbiter #(NREQ): inputs req, ptr; outputs one-hot grant and encoded index. This is purely combinational and reusable by the vector unit.
- Datapath: one instance of the existing multiplier #(N); no duplicate arithmetic.

Test Plan:
- Reset then idle, req_valid=0 -> rsp_valid=0, busy=0, req_ready=0000 for 10 cycles.
- Single op: req 1, a=3, b=5, rsp_ready=1, accepted in cycle t -> cycle t+2: rsp_valid=1, result=15, flags=0000, id=1.
- Flag cases, each from requester 0:
  - a=0, b=7 -> result 0, flags 1000.
  - a=0x8000_0000, b=2 -> result 0, flags 1010.
  - a=0xFFFF_FFFF, b=1 -> result 0xFFFF_FFFF, flags 0100.
  - a=0x4000_0000, b=2 -> result 0x8000_0000, flags 0101.
- Round-robin: all 4 requesters hold valid with rsp_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; rsp_id follows 0,1,2,3 from t+2.
- Backpressure: continuous requests, rsp_ready=0 for 3 cycles:
  - Response outputs stay frozen.
  - Exactly 2 ops are in flight.
  - req_ready=0000 after S1 fills.
  - After release, responses resume in order with no gap or duplicate.
- Reset mid-flight: assert rst for 1 cycle with S1 and S2 full -> no response for the dropped ops, rr_ptr=0. The next request from 2 returns id=2 two cycles after acceptance.
